// File: rtl/pulse_channel_gen2_if.sv
// Register-file side of the square-wave channel: NRx0..NRx4 plus the
// (re)start pulse. master = register file, slave = channel.
interface pulse_channel_gen2_if;
  logic       iTrigger;
  logic [7:0] iNR10;
  logic [7:0] iNR11;
  logic [7:0] iNR12;
  logic [7:0] iNR13;
  logic [7:0] iNR14;

  modport master (
    output iTrigger,
    output iNR10,
    output iNR11,
    output iNR12,
    output iNR13,
    output iNR14
  );

  modport slave (
    input iTrigger,
    input iNR10,
    input iNR11,
    input iNR12,
    input iNR13,
    input iNR14
  );
endinterface

// File: rtl/pulse_channel_gen2.sv
// Square-wave sound channel: duty sequencer, sweep, length, envelope.
// Ports: iClock/iReset (sync, high), tick enables, regs (NRx bus),
// oOut offset-binary sample, oActive channel status.
module pulse_channel_gen2 #(
  parameter int FREQ_W    = 11,
  parameter int VOL_W     = 4,
  parameter int LEN_W     = 6,
  parameter int OUT_W     = 5,
  parameter bit HAS_SWEEP = 1'b1
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iTickFreq,
  input  logic             iTick256,
  input  logic             iTick128,
  input  logic             iTick64,
  pulse_channel_gen2_if.slave regs,
  output logic [OUT_W-1:0] oOut,
  output logic             oActive
);

  localparam logic [FREQ_W:0] FREQ_SPAN = {1'b1, {FREQ_W{1'b0}}};
  localparam logic [FREQ_W:0] FREQ_ONE  = (FREQ_W+1)'(1);
  localparam logic [LEN_W:0]  LEN_SPAN  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]  LEN_ONE   = (LEN_W+1)'(1);
  localparam logic [VOL_W-1:0] VOL_ONE  = VOL_W'(1);
  localparam logic [OUT_W-1:0] MID      = OUT_W'(2**(OUT_W-1) - 1);

  logic [FREQ_W-1:0] fIn;
  logic              dacOn;
  logic [2:0]        perIn;
  logic [2:0]        shiftIn;
  logic              subIn;
  logic [FREQ_W:0]   trigNew;
  logic              trigOvf;

  logic              active;
  logic [FREQ_W:0]   freqTimer;
  logic [2:0]        pos;
  logic [1:0]        duty;
  logic [FREQ_W-1:0] freqInt;
  logic [LEN_W:0]    lenCnt;
  logic              lenEn;
  logic [VOL_W-1:0]  vol;
  logic [2:0]        envCnt;
  logic [2:0]        envPer;
  logic              envUp;
  logic [FREQ_W-1:0] shadow;
  logic [3:0]        sweepCnt;
  logic [2:0]        sweepPer;
  logic              sweepSub;
  logic [2:0]        sweepShift;
  logic              sweepEn;

  logic [FREQ_W:0]   shadowExt;
  logic [FREQ_W:0]   sweepNew;
  logic [3:0]        sweepReload;
  logic              dutyBit;
  logic [7:0]        pattern;
  logic [OUT_W-1:0]  volOut;
  logic              unusedBits;

  assign fIn     = {regs.iNR14[FREQ_W-9:0], regs.iNR13};
  assign dacOn   = |regs.iNR12[7:3];
  assign perIn   = regs.iNR10[6:4];
  assign subIn   = regs.iNR10[3];
  assign shiftIn = regs.iNR10[2:0];

  // One extra bit so an add past the top register value is visible.
  assign trigNew = {1'b0, fIn} + ({1'b0, fIn} >> shiftIn);
  assign trigOvf = HAS_SWEEP && (shiftIn != 3'd0) && !subIn
                && trigNew[FREQ_W];

  assign shadowExt = {1'b0, shadow};
  assign sweepNew  = sweepSub
                   ? shadowExt - (shadowExt >> sweepShift)
                   : shadowExt + (shadowExt >> sweepShift);
  assign sweepReload = (sweepPer == 3'd0) ? 4'd8 : {1'b0, sweepPer};

  assign volOut     = OUT_W'(vol);
  assign unusedBits = ^{regs.iNR10, regs.iNR11, regs.iNR14};

  // Patterns are time-ordered: string position 0 is the first step,
  // so each constant is the written waveform bit-reversed.
  always_comb begin
    pattern = 8'h00;
    unique case (duty)
      2'b00: pattern = 8'b1000_0000;
      2'b01: pattern = 8'b1000_0001;
      2'b10: pattern = 8'b1110_0001;
      2'b11: pattern = 8'b0111_1110;
      default: pattern = 8'h00;
    endcase
    dutyBit = pattern[pos];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      active     <= 1'b0;
      freqTimer  <= '0;
      pos        <= '0;
      duty       <= '0;
      freqInt    <= '0;
      lenCnt     <= '0;
      lenEn      <= 1'b0;
      vol        <= '0;
      envCnt     <= '0;
      envPer     <= '0;
      envUp      <= 1'b0;
      shadow     <= '0;
      sweepCnt   <= '0;
      sweepPer   <= '0;
      sweepSub   <= 1'b0;
      sweepShift <= '0;
      sweepEn    <= 1'b0;
      oOut       <= MID;
      oActive    <= 1'b0;
    end else begin
      if (regs.iTrigger) begin
        active     <= dacOn && !trigOvf;
        freqTimer  <= FREQ_SPAN - {1'b0, fIn};
        freqInt    <= fIn;
        duty       <= regs.iNR11[7:6];
        lenCnt     <= LEN_SPAN
                    - {1'b0, regs.iNR11[LEN_W-1:0]};
        lenEn      <= regs.iNR14[6];
        vol        <= VOL_W'(regs.iNR12[7:4]);
        envPer     <= regs.iNR12[2:0];
        envCnt     <= regs.iNR12[2:0];
        envUp      <= regs.iNR12[3];
        shadow     <= fIn;
        sweepPer   <= perIn;
        sweepSub   <= subIn;
        sweepShift <= shiftIn;
        sweepCnt   <= (perIn == 3'd0) ? 4'd8 : {1'b0, perIn};
        sweepEn    <= HAS_SWEEP
                   && ((perIn != 3'd0) || (shiftIn != 3'd0));
      end else begin
        if (iTickFreq) begin
          if (freqTimer <= FREQ_ONE) begin
            freqTimer <= FREQ_SPAN - {1'b0, freqInt};
            pos       <= pos + 3'd1;
          end else begin
            freqTimer <= freqTimer - FREQ_ONE;
          end
        end
        if (iTick256 && lenEn && (lenCnt != '0)) begin
          lenCnt <= lenCnt - LEN_ONE;
          if (lenCnt == LEN_ONE) active <= 1'b0;
        end
        if (iTick64 && (envPer != 3'd0)) begin
          if (envCnt <= 3'd1) begin
            envCnt <= envPer;
            if (envUp && (vol != '1)) vol <= vol + VOL_ONE;
            else if (!envUp && (vol != '0)) vol <= vol - VOL_ONE;
          end else begin
            envCnt <= envCnt - 3'd1;
          end
        end
        if (HAS_SWEEP && iTick128 && sweepEn) begin
          if (sweepCnt <= 4'd1) begin
            sweepCnt <= sweepReload;
            if (sweepPer != 3'd0) begin
              if (sweepNew[FREQ_W]) begin
                active <= 1'b0;
              end else if (sweepShift != 3'd0) begin
                shadow  <= sweepNew[FREQ_W-1:0];
                freqInt <= sweepNew[FREQ_W-1:0];
              end
            end
          end else begin
            sweepCnt <= sweepCnt - 4'd1;
          end
        end
      end
      // The DAC gate overrides everything, trigger included.
      if (!dacOn) active <= 1'b0;
      oActive <= active;
      if (!active)     oOut <= MID;
      else if (dutyBit) oOut <= MID + volOut;
      else             oOut <= MID - volOut;
    end
  end

endmodule

// File: tb/tb_pulse_channel_gen2.sv
// Directed bench for pulse_channel_gen2: reset, duty walk, then a
// per-cycle vector table for length, envelope, DAC and sweep cases.
module tb_pulse_channel_gen2;
  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iTickFreq = 1'b0;
  logic       iTick256 = 1'b0;
  logic       iTick128 = 1'b0;
  logic       iTick64 = 1'b0;
  logic [4:0] oOut;
  logic       oActive;

  pulse_channel_gen2_if regs();

  pulse_channel_gen2 dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iTickFreq(iTickFreq),
    .iTick256 (iTick256),
    .iTick128 (iTick128),
    .iTick64  (iTick64),
    .regs     (regs),
    .oOut     (oOut),
    .oActive  (oActive)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit         rst;
    bit         trig;
    bit         t256;
    bit         t128;
    bit         t64;
    logic [7:0] nr10;
    logic [7:0] nr11;
    logic [7:0] nr12;
    logic [7:0] nr13;
    logic [7:0] nr14;
    bit         chk;
    logic [4:0] eOut;
    bit         eAct;
    string      name;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] c10, c11, c13, c14;
  int nVec = 0;
  int nBad = 0;
  int dutyExp[16] = '{30, 30, 0, 0, 0, 0, 0, 0,
                      0, 0, 30, 30, 30, 30, 30, 30};

  task automatic setR(input logic [7:0] a, b, c, d);
    c10 = a; c11 = b; c13 = c; c14 = d;
  endtask

  task automatic add(input bit rst, trig, t256, t128, t64,
                     input logic [7:0] nr12, input bit chk,
                     input int eo, input bit ea,
                     input string nm);
    vec_t v;
    v.rst = rst; v.trig = trig;
    v.t256 = t256; v.t128 = t128; v.t64 = t64;
    v.nr10 = c10; v.nr11 = c11; v.nr12 = nr12;
    v.nr13 = c13; v.nr14 = c14;
    v.chk = chk; v.eOut = 5'(eo); v.eAct = ea;
    v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input int eo,
                     input bit ea);
    nVec++;
    if (oOut !== 5'(eo) || oActive !== ea) begin
      nBad++;
      $display("FAIL %s: out=%0d act=%0b, expected out=%0d act=%0b",
               nm, oOut, oActive, eo, ea);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  initial begin
    regs.iTrigger = 1'b0;
    regs.iNR10 = '0; regs.iNR11 = '0; regs.iNR12 = '0;
    regs.iNR13 = '0; regs.iNR14 = '0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      iReset = 1'b1;
      regs.iTrigger = 1'($urandom);
      regs.iNR10 = 8'($urandom); regs.iNR11 = 8'($urandom);
      regs.iNR12 = 8'($urandom); regs.iNR13 = 8'($urandom);
      regs.iNR14 = 8'($urandom);
      iTickFreq = 1'($urandom); iTick256 = 1'($urandom);
      iTick128 = 1'($urandom); iTick64 = 1'($urandom);
      tick();
    end
    cmp("reset", 15, 1'b0);
    iReset = 1'b0; regs.iTrigger = 1'b0;
    iTickFreq = 0; iTick256 = 0; iTick128 = 0; iTick64 = 0;
    regs.iNR10 = '0; regs.iNR11 = '0; regs.iNR12 = '0;
    tick();
    cmp("reset idle", 15, 1'b0);

    // F=2046, duty 10, vol 15: period of 2 freq ticks.
    regs.iNR10 = 8'h00; regs.iNR11 = 8'h80;
    regs.iNR12 = 8'hF0; regs.iNR13 = 8'hFE;
    regs.iNR14 = 8'h07;
    regs.iTrigger = 1'b1; iTickFreq = 1'b1;
    tick();
    regs.iTrigger = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cmp($sformatf("duty%0d", k), dutyExp[k], 1'b1);
    end
    iTickFreq = 1'b0;

    // Position is back at 0; duty 10 gives bit 1 there.
    setR(8'h00, 8'hBE, 8'hFE, 8'h47);
    add(0, 1, 0, 0, 0, 8'hF0, 1, 30, 1, "len trig");
    add(0, 0, 1, 0, 0, 8'hF0, 1, 30, 1, "len t1");
    add(0, 0, 1, 0, 0, 8'hF0, 1, 30, 1, "len t2");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "len off");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "len hold");

    add(0, 1, 1, 0, 0, 8'hF0, 1, 15, 0, "col trig");
    add(0, 0, 1, 0, 0, 8'hF0, 1, 30, 1, "col t1");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 30, 1, "col mid");
    add(0, 0, 1, 0, 0, 8'hF0, 1, 30, 1, "col t2");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "col off");

    setR(8'h00, 8'h80, 8'hFE, 8'h07);
    add(0, 1, 0, 0, 0, 8'h21, 1, 15, 0, "envd trig");
    add(0, 0, 0, 0, 0, 8'h21, 1, 17, 1, "envd v2");
    add(0, 0, 0, 0, 1, 8'h21, 1, 17, 1, "envd t1");
    add(0, 0, 0, 0, 0, 8'h21, 1, 16, 1, "envd v1");
    add(0, 0, 0, 0, 1, 8'h21, 1, 16, 1, "envd t2");
    add(0, 0, 0, 0, 0, 8'h21, 1, 15, 1, "envd v0");
    add(0, 0, 0, 0, 1, 8'h21, 1, 15, 1, "envd t3");
    add(0, 0, 0, 0, 0, 8'h21, 1, 15, 1, "envd sat");

    add(0, 1, 0, 0, 0, 8'hE9, 1, 15, 1, "envu trig");
    add(0, 0, 0, 0, 0, 8'hE9, 1, 29, 1, "envu v14");
    add(0, 0, 0, 0, 1, 8'hE9, 1, 29, 1, "envu t1");
    add(0, 0, 0, 0, 0, 8'hE9, 1, 30, 1, "envu v15");
    add(0, 0, 0, 0, 1, 8'hE9, 1, 30, 1, "envu t2");
    add(0, 0, 0, 0, 0, 8'hE9, 1, 30, 1, "envu sat");

    add(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "dac edge");
    add(0, 0, 0, 0, 0, 8'h00, 1, 15, 0, "dac off");
    add(0, 1, 0, 0, 0, 8'h00, 1, 15, 0, "dac trig");
    add(0, 0, 0, 0, 0, 8'h00, 1, 15, 0, "dac stay");

    setR(8'h11, 8'h80, 8'hDC, 8'h05);
    add(0, 1, 0, 0, 0, 8'hF0, 1, 15, 0, "ovf trig");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "ovf now");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "ovf hold");

    setR(8'h11, 8'h80, 8'hE8, 8'h03);
    add(0, 1, 0, 0, 0, 8'hF0, 1, 15, 0, "swp trig");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 30, 1, "swp on");
    add(0, 0, 0, 1, 0, 8'hF0, 1, 30, 1, "swp t1");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 30, 1, "swp 1500");
    add(0, 0, 0, 1, 0, 8'hF0, 1, 30, 1, "swp t2");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "swp off");

    setR(8'h19, 8'h80, 8'hD0, 8'h07);
    add(0, 1, 0, 0, 0, 8'hF0, 1, 15, 0, "sub trig");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 30, 1, "sub on");
    add(0, 0, 0, 1, 0, 8'hF0, 1, 30, 1, "sub t1");
    add(0, 0, 0, 1, 0, 8'hF0, 1, 30, 1, "sub t2");
    add(0, 0, 0, 1, 0, 8'hF0, 1, 30, 1, "sub t3");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 30, 1, "sub stay");

    add(1, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "mid rst");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "post rst");
    add(0, 0, 0, 0, 0, 8'hF0, 1, 15, 0, "post idle");

    foreach (tbl[i]) begin
      iReset = tbl[i].rst;
      regs.iTrigger = tbl[i].trig;
      iTick256 = tbl[i].t256;
      iTick128 = tbl[i].t128;
      iTick64 = tbl[i].t64;
      regs.iNR10 = tbl[i].nr10;
      regs.iNR11 = tbl[i].nr11;
      regs.iNR12 = tbl[i].nr12;
      regs.iNR13 = tbl[i].nr13;
      regs.iNR14 = tbl[i].nr14;
      tick();
      if (tbl[i].chk)
        cmp(tbl[i].name, int'(tbl[i].eOut), tbl[i].eAct);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end
endmodule

// File: doc/pulse_channel_gen2.md
# pulse_channel_gen2

Parametrised second-generation square-wave sound channel: an 8-step duty sequencer, frequency sweep with overflow shutdown, length timer and volume envelope, all in one clock domain. Frame-sequencer rates arrive as single-cycle tick enables rather than separate clocks. The block sits between the sound register file (NRx0..NRx4) and the channel mixer. The same RTL serves channel 1 (`HAS_SWEEP=1`) and channel 2 (`HAS_SWEEP=0`).

## Interface
- `FREQ_W`, 11: frequency register width; timer period = 2^FREQ_W − F.
- `VOL_W`, 4: envelope volume width.
- `LEN_W`, 6: length field width; length runs 1..2^LEN_W ticks.
- `OUT_W`, 5: output width; must be ≥ VOL_W+1.
- `HAS_SWEEP`, 1: 0 removes the sweep unit and ignores `iNR10`.

Ports:
- `iClock`  in  1  system clock; the only clock.
- `iReset`  in  1  synchronous, active-high reset.
- `iTickFreq`  in  1  one-cycle enable at the frequency-timer rate (nominally 1048576 Hz).
- `iTick256`  in  1  one-cycle length-timer enable.
- `iTick128`  in  1  one-cycle sweep enable.
- `iTick64`  in  1  one-cycle envelope enable.
- `iTrigger`  in  1  one-cycle channel (re)start pulse; edge detection is done upstream.
- `iNR10`  in  8  [6:4] sweep period, [3] 1=subtract, [2:0] shift.
- `iNR11`  in  8  [7:6] duty, [LEN_W-1:0] length load L.
- `iNR12`  in  8  [7:4] initial volume, [3] 1=up, [2:0] envelope period.
- `iNR13`  in  8  F[7:0].
- `iNR14`  in  8  [6] length enable, [FREQ_W-9:0] F high bits.
- `oOut`  out  OUT_W  offset-binary sample; MID = 2^(OUT_W-1) − 1.
- `oActive`  out  1  channel enabled (status bit for NR52).

## Operation
- **Reset:**
  - `oOut` = MID; `oActive` = 0.
  - All counters, the duty position, the volume and the shadow frequency are 0.
- **Trigger:** all of the following load in the cycle `iTrigger` is high.
  - active = 1 unless the DAC is off (`iNR12[7:3]`==0).
  - Freq timer = 2^FREQ_W − F; duty position unchanged.
  - Length counter = 2^LEN_W − L; length enable and duty are latched.
  - Volume = `iNR12[7:4]`; envelope counter = envelope period; direction latched.
  - Sweep: shadow = F; sweep counter = period (0 reloads as 8); sweep_en = (period≠0) | (shift≠0).
  - If shift≠0 and add mode, run the overflow check immediately.
- **Frequency timer:** decrements on `iTickFreq`. When it reads 1, it reloads 2^FREQ_W − F and the position advances 0→7, wrapping to 0.
- **Duty patterns** (bit index = position):
  - 00 → 00000001
  - 01 → 10000001
  - 10 → 10000111
  - 11 → 01111110
- **Length:** on `iTick256`, if length is enabled and the counter ≠ 0, decrement. Reaching 0 sets active = 0.
- **Envelope:** on `iTick64`, if period ≠ 0, decrement the counter.
  - At expiry, reload the period and step volume ±1.
  - Volume saturates at 0 and at 2^VOL_W − 1, with no wrap.
- **Sweep** (HAS_SWEEP=1): on `iTick128`, if sweep_en, decrement the counter. At expiry, reload it (0→8); then, if period ≠ 0:
  - new = shadow ± (shadow >> shift), computed FREQ_W+1 bits wide.
  - new > 2^FREQ_W − 1 → active = 0.
  - Otherwise, if shift ≠ 0: shadow = new and F_internal = new.
  - Subtract mode cannot underflow.
- **DAC off:** `iNR12[7:3]`==0 at any time forces active = 0 immediately, with no trigger needed.
- **Output:**
  - `oOut` = MID + vol when active and the duty bit is 1.
  - `oOut` = MID − vol when active and the duty bit is 0.
  - `oOut` = MID when inactive.

## Timing
- All state updates on the rising edge of `iClock`; ticks are sampled as enables.
- `oOut` and `oActive` are registered: 1-cycle latency from the internal state change.
- **Priority in a single cycle:** `iReset` > `iTrigger` > tick processing. A tick coinciding with a trigger is discarded for that unit.
- Several ticks in the same cycle are processed independently. A sweep-overflow disable and a length disable in the same cycle both simply clear active.
- A trigger while active restarts every counter, as defined under Trigger.
- `iReset` mid-note restores all reset values on the next edge.
- Register inputs are not sampled between triggers, except the `iNR12` DAC check.

## Test plan
- **Reset:** assert `iReset` 2 cycles with random inputs → `oOut`=15, `oActive`=0 (OUT_W=5).
- **Duty/frequency:**
  - Stimulus: F=2046, duty=10, vol=15, envelope period 0, trigger, `iTickFreq` every cycle.
  - Response: position advances every 2 ticks; `oOut` sequence over 16 ticks is 30 ×2, 0 ×8, 30 ×6 (pattern 10000111 read bit 0 first).
- **Length:** L=62, length enable=1, trigger, 2 `iTick256` pulses → `oActive` falls 1 cycle after the 2nd tick; `oOut`=15 thereafter.
- **Envelope:** vol=2, down, period 1 → after 2 `iTick64` pulses vol=0; a 3rd pulse keeps vol=0. Up mode from 14 saturates at 15.
- **Sweep overflow:**
  - F=1500, add, shift=1, period=1, trigger → trigger-time check gives 2250 > 2047, so `oActive` = 0.
  - F=1000, add, shift=1 → after 1 `iTick128`, F becomes 1500; the 2nd tick disables the channel.
- **Collisions:**
  - Trigger and `iTick256` in the same cycle: the length counter equals the fresh load.
  - `iNR12`=0x00 during a note: `oActive` = 0 on the next cycle.
